// File: rtl/stream_rr_arbiter.sv
// Per-master-port packet arbiter for a stream crossbar: picks one eligible slave
// in round-robin (optionally weighted) order and holds it until the last beat.
module stream_rr_arbiter #(
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3,
  parameter int PORT_ID      = 0,
  parameter int ARB_MODE     = 0,
  parameter int WEIGHT_WIDTH = 4,
  localparam int ID_W   = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1,
  localparam int DEST_W = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [S_DATA_COUNT-1:0]          s_valid_i,
  input  logic [S_DATA_COUNT*DEST_W-1:0]   s_dest_i,
  input  logic [S_DATA_COUNT-1:0]          s_last_i,
  output logic [S_DATA_COUNT-1:0]          s_ready_o,
  input  logic [S_DATA_COUNT*WEIGHT_WIDTH-1:0] weight_i,
  input  logic                             m_ready_i,
  output logic                             m_valid_o,
  output logic                             m_last_o,
  output logic [ID_W-1:0]                  grant_o,
  output logic                             grant_valid_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         grant_q, grant_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [WEIGHT_WIDTH-1:0] cnt_q, cnt_d;

  logic [S_DATA_COUNT-1:0] elig;
  logic [WEIGHT_WIDTH-1:0] weight_arr [S_DATA_COUNT];

  generate
    for (genvar gi = 0; gi < S_DATA_COUNT; gi++) begin : g_slave
      assign elig[gi]       = s_valid_i[gi] &&
                              (s_dest_i[gi*DEST_W +: DEST_W] == DEST_W'(PORT_ID));
      assign weight_arr[gi] = weight_i[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  endgenerate

  // Search from ptr upward with explicit wrap so non-power-of-2 counts never
  // produce an out-of-range index.
  logic            found;
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] cand;
  int              idx;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int k = 0; k < S_DATA_COUNT; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= S_DATA_COUNT) idx = idx - S_DATA_COUNT;
      cand = ID_W'(idx);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  logic                    beat, last_beat;
  logic [ID_W-1:0]         ptr_inc;
  logic [WEIGHT_WIDTH-1:0] w_eff;
  logic [WEIGHT_WIDTH:0]   cnt_plus;

  assign beat      = (state_q == BUSY) && s_valid_i[grant_q] && m_ready_i;
  assign last_beat = beat && s_last_i[grant_q];
  assign ptr_inc   = (grant_q == ID_W'(S_DATA_COUNT - 1)) ? '0 : grant_q + ID_W'(1);
  assign w_eff     = (weight_arr[grant_q] == '0) ? WEIGHT_WIDTH'(1) : weight_arr[grant_q];
  assign cnt_plus  = {1'b0, cnt_q} + (WEIGHT_WIDTH+1)'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = pick;
          // A new slave starts its turn with a fresh credit count.
          if (pick != grant_q) cnt_d = '0;
        end
      end
      BUSY: begin
        if (last_beat) begin
          state_d = IDLE;
          if (ARB_MODE == 1) begin
            if (cnt_plus >= {1'b0, w_eff}) begin
              ptr_d = ptr_inc;
              cnt_d = '0;
            end else begin
              ptr_d = grant_q;
              cnt_d = cnt_plus[WEIGHT_WIDTH-1:0];
            end
          end else begin
            ptr_d = ptr_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs are also gated by rst so nothing leaks before the first edge.
  always_comb begin
    s_ready_o     = '0;
    m_valid_o     = 1'b0;
    m_last_o      = 1'b0;
    grant_valid_o = 1'b0;
    grant_o       = grant_q;
    if (!rst && state_q == BUSY) begin
      s_ready_o[grant_q] = m_ready_i;
      m_valid_o          = s_valid_i[grant_q];
      m_last_o           = s_last_i[grant_q];
      grant_valid_o      = 1'b1;
    end
  end

endmodule
